// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Also intended for reuse by the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int frame_bits(
        input int data_bits,
        input int parity_en,
        input int stop_bits
    );
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_baud_edge_det.sv
// Synchronises the divided baud signal and emits a one-cycle
// tick on each rising edge, three in_clk cycles after the edge.
module baud_edge_det (
    input  logic in_clk,
    input  logic nrst,
    input  logic baud_clk,
    output logic tick
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic tick_q;

    // Two-flop synchroniser, edge history and registered tick.
    always_ff @(posedge in_clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= baud_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            tick_q  <= sync2_q & ~prev_q;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// Bit timing comes from the divider output, used only as data.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 in_clk,
    input  logic                 nrst,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
    localparam logic LAST_STOP = (STOP_BITS > 1) ? 1'b1 : 1'b0;
    localparam logic ODD_BIT = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 tick;
    logic                 accept;

    baud_edge_det u_edge (
        .in_clk   (in_clk),
        .nrst     (nrst),
        .baud_clk (baud_clk),
        .tick     (tick)
    );

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;
    assign accept   = tx_valid & tx_ready;

    // State, datapath and line registers; line idles high in reset.
    always_ff @(posedge in_clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    // Next-state and next line level; only ticks advance a frame.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    shift_d    = tx_data;
                    par_d      = (^tx_data) ^ ODD_BIT;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[1];
                    end else if (PARITY_EN != 0) begin
                        tx_d    = par_q;
                        state_d = PARITY;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three parameterisations share
// one clock, one reset and a modelled 10-cycle baud divider.
module tb_uart_tx;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       baud = 1'b0;
    bit         baud_run = 1'b1;
    logic [7:0] td [3];
    logic       tv [3];
    logic       tx_w [3];
    logic       by_w [3];
    logic       rd_w [3];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         acc0 = 0;
    exp_t       sb_q [$];

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .in_clk(clk), .nrst(nrst), .baud_clk(baud), .tx_data(td[0]),
        .tx_valid(tv[0]), .tx_ready(rd_w[0]), .tx(tx_w[0]), .busy(by_w[0]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
        .in_clk(clk), .nrst(nrst), .baud_clk(baud), .tx_data(td[1]),
        .tx_valid(tv[1]), .tx_ready(rd_w[1]), .tx(tx_w[1]), .busy(by_w[1]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .in_clk(clk), .nrst(nrst), .baud_clk(baud), .tx_data(td[2]),
        .tx_valid(tv[2]), .tx_ready(rd_w[2]), .tx(tx_w[2]), .busy(by_w[2]));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (tv[0] === 1'b1 && rd_w[0] === 1'b1) acc0 = acc0 + 1;
    end

    // Divider model: toggles every 5 cycles, 10-cycle bit time.
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            if (baud_run) begin
                c++;
                if (c == 5) begin
                    c = 0;
                    baud = ~baud;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rise(output bit to);
        logic p;
        int n;
        to = 1'b0;
        n = 0;
        p = baud;
        forever begin
            @(posedge clk);
            if (baud && !p) break;
            p = baud;
            n++;
            if (n > 400) begin
                to = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input int id, input logic [7:0] b);
        int n;
        exp_t e;
        e.data = b;
        e.par = (^b) ^ (id == 2);
        sb_q.push_back(e);
        n = 0;
        while (rd_w[id] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("send_ready_to", 1, 0);
            return;
        end
        td[id] = b;
        tv[id] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tv[id] = 1'b0;
        chk("busy_after_acc", 32'(by_w[id]), 1);
        chk("rdy_after_acc", 32'(rd_w[id]), 0);
    endtask

    task automatic rx_frame(input int id, input int par_en,
                            input int stop_bits, output int t_fall);
        bit to;
        int n;
        int blen;
        int bad;
        logic [7:0] d;
        logic p;
        exp_t e;
        t_fall = 0;
        p = 1'b0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        n = 0;
        @(negedge clk);
        while (tx_w[id] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("rx_start_to", 1, 0);
            return;
        end
        t_fall = cyc;
        wait_rise(to);
        if (to) begin
            chk("rx_baud_to", 1, 0);
            return;
        end
        chk("rx_start_bit", 32'(tx_w[id]), 0);
        for (int i = 0; i < 8; i++) begin
            wait_rise(to);
            if (to) begin
                chk("rx_baud_to", 1, 0);
                return;
            end
            d[i] = tx_w[id];
        end
        if (par_en != 0) begin
            wait_rise(to);
            if (to) begin
                chk("rx_baud_to", 1, 0);
                return;
            end
            p = tx_w[id];
        end
        blen = 0;
        bad = 0;
        while (by_w[id] === 1'b1 && blen < 1000) begin
            if (blen >= 3 && tx_w[id] !== 1'b1) bad++;
            @(negedge clk);
            blen++;
        end
        chk("rx_data", 32'(d), 32'(e.data));
        if (par_en != 0) chk("rx_parity", 32'(p), 32'(e.par));
        chk("rx_stop_len", blen, 10 * stop_bits + 3);
        chk("rx_stop_high", bad, 0);
        chk("rx_idle_tx", 32'(tx_w[id]), 1);
    endtask

    // Exact run-length check; valid for alternating patterns only.
    task automatic rx_runs(input int id);
        int n;
        int run;
        logic cur;
        logic lvl;
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        n = 0;
        while (tx_w[id] !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("runs_start_to", 1, 0);
            return;
        end
        for (int k = 0; k < 9; k++) begin
            lvl = (k == 0) ? 1'b0 : e.data[k-1];
            cur = tx_w[id];
            chk("runs_level", 32'(cur), 32'(lvl));
            run = 0;
            while (tx_w[id] === cur && run < 100) begin
                @(negedge clk);
                run++;
            end
            chk("runs_len", run, 10);
        end
    endtask

    initial begin
        int t1;
        int t2;
        int a0;
        int n;
        int cnt;
        bit to;
        for (int i = 0; i < 3; i++) begin
            td[i] = 8'h00;
            tv[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("por_tx", 32'(tx_w[i]), 1);
            chk("por_busy", 32'(by_w[i]), 0);
            chk("por_rdy", 32'(rd_w[i]), 1);
        end
        nrst = 1'b1;
        repeat (20) @(negedge clk);

        fork
            send(0, 8'h55);
            rx_runs(0);
        join
        repeat (30) @(negedge clk);
        fork
            send(0, 8'hC6);
            rx_frame(0, 0, 1, t1);
        join

        nrst = 1'b0;
        #1;
        chk("rst_tx", 32'(tx_w[0]), 1);
        chk("rst_busy", 32'(by_w[0]), 0);
        chk("rst_rdy", 32'(rd_w[0]), 1);
        repeat (5) @(negedge clk);
        chk("rst_hold_tx", 32'(tx_w[0]), 1);
        chk("rst_hold_rdy", 32'(rd_w[0]), 1);
        nrst = 1'b1;
        repeat (20) @(negedge clk);

        fork
            send(1, 8'h07);
            rx_frame(1, 1, 2, t1);
        join
        fork
            send(1, 8'hC3);
            rx_frame(1, 1, 2, t1);
        join
        fork
            send(2, 8'h07);
            rx_frame(2, 1, 1, t1);
        join

        sb_q.push_back('{data: 8'hA5, par: 1'b0});
        sb_q.push_back('{data: 8'h3C, par: 1'b0});
        a0 = acc0;
        fork
            begin
                @(negedge clk);
                td[0] = 8'hA5;
                tv[0] = 1'b1;
                @(posedge clk);
                @(negedge clk);
                td[0] = 8'h3C;
                n = 0;
                while (by_w[0] === 1'b1 && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                cnt = 0;
                while (by_w[0] === 1'b0 && cnt < 100) begin
                    @(negedge clk);
                    cnt++;
                end
                tv[0] = 1'b0;
                chk("b2b_idle_cycles", cnt, 1);
            end
            begin
                rx_frame(0, 0, 1, t1);
                rx_frame(0, 0, 1, t2);
            end
        join
        chk("b2b_spacing", t2 - t1, 10 * (frame_bits(8, 0, 1) + 1));
        chk("b2b_accepts", acc0 - a0, 2);
        repeat (30) @(negedge clk);

        fork
            send(0, 8'hF0);
            begin
                n = 0;
                while (tx_w[0] !== 1'b0 && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 4; i++) wait_rise(to);
                repeat (5) @(negedge clk);
                chk("mid_d3_low", 32'(tx_w[0]), 0);
                nrst = 1'b0;
                #1;
                chk("mid_rst_tx", 32'(tx_w[0]), 1);
                chk("mid_rst_busy", 32'(by_w[0]), 0);
                chk("mid_rst_rdy", 32'(rd_w[0]), 1);
            end
        join
        void'(sb_q.pop_front());
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        fork
            send(0, 8'h81);
            rx_frame(0, 0, 1, t1);
        join
        repeat (30) @(negedge clk);

        a0 = acc0;
        fork
            begin
                send(0, 8'h3C);
                repeat (35) @(negedge clk);
                td[0] = 8'hFF;
                tv[0] = 1'b1;
                @(negedge clk);
                tv[0] = 1'b0;
                repeat (20) @(negedge clk);
                baud_run = 1'b0;
                repeat (200) @(negedge clk);
                chk("stall_busy", 32'(by_w[0]), 1);
                baud_run = 1'b1;
            end
            rx_frame(0, 0, 1, t1);
        join
        chk("intf_accepts", acc0 - a0, 1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (by_w[0] !== 1'b0) cnt++;
        end
        chk("intf_no_frame", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
